// File: rtl/mul_23_recon_if.sv
// Handshake bus for mul_23_recon: Q/R pair in, reconstructed dividend X out.
interface mul_23_recon_if;
  logic        in_valid;
  logic        in_ready;
  logic [59:0] Q_in;
  logic [4:0]  R_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] X_out;
  logic        err_out;

  modport master (
    output in_valid, Q_in, R_in, out_ready,
    input  in_ready, out_valid, X_out, err_out
  );

  modport slave (
    input  in_valid, Q_in, R_in, out_ready,
    output in_ready, out_valid, X_out, err_out
  );
endinterface

// File: rtl/mul_23_recon.sv
// Serial shift-add reconstruction X = 23*Q + R, one constant bit per cycle.
// Optional RECON_ERR_EN builds the R >= 23 and 64-bit overflow detection on err_out.
module mul_23_recon (
  input  logic         clk,
  input  logic         rst_n,
  mul_23_recon_if.slave bus
);

`ifdef RECON_ERR_EN
  localparam int ACC_W = 66;
`else
  localparam int ACC_W = 64;
`endif

  // Bits of the constant 23, padded so every 3-bit step index selects a defined bit.
  localparam logic [7:0] K_BITS = 8'b0001_0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [59:0]      q_reg_q, q_reg_d;
  logic [2:0]       k_q, k_d;
  logic [63:0]      x_q, x_d;
  logic             err_q, err_d;
`ifdef RECON_ERR_EN
  logic             r_big_q, r_big_d;
`endif

  // Next-state and datapath: accept, shift-add over k = 0..4, then hold result.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_reg_d = q_reg_q;
    k_d     = k_q;
    x_d     = x_q;
    err_d   = err_q;
`ifdef RECON_ERR_EN
    r_big_d = r_big_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          q_reg_d = bus.Q_in;
          acc_d   = {{(ACC_W-5){1'b0}}, bus.R_in};
          k_d     = 3'd0;
`ifdef RECON_ERR_EN
          r_big_d = (bus.R_in >= 5'd23);
`endif
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (K_BITS[k_q]) begin
          acc_d = acc_q + ({{(ACC_W-60){1'b0}}, q_reg_q} << k_q);
        end else begin
          acc_d = acc_q;
        end
        k_d = k_q + 3'd1;
        if (k_q == 3'd4) begin
          state_d = DONE;
          x_d     = acc_d[63:0];
`ifdef RECON_ERR_EN
          err_d   = r_big_q | (acc_d[65:64] != 2'b00);
`else
          err_d   = 1'b0;
`endif
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      q_reg_q <= '0;
      k_q     <= 3'd0;
      x_q     <= 64'd0;
      err_q   <= 1'b0;
`ifdef RECON_ERR_EN
      r_big_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_reg_q <= q_reg_d;
      k_q     <= k_d;
      x_q     <= x_d;
      err_q   <= err_d;
`ifdef RECON_ERR_EN
      r_big_q <= r_big_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.X_out     = x_q;
  assign bus.err_out   = err_q;

endmodule
